// File: rtl/efpga_cfg_pkg.sv
// Shared definitions for the eFPGA Wishbone frame loader:
// register map, STATUS layout, FSM states and derived widths.
package efpga_cfg_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_ROW    = 2'd2;
    localparam logic [1:0] REG_DATA   = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_CLR   = 1;
    localparam int ST_BUSY    = 8;
    localparam int ST_ERR     = 9;
    localparam int ST_CNT_LSB = 16;

    localparam int ROW_W = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STROBE,
        S_HOLD
    } cfg_state_e;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/efpga_wb_cfg_loader_if.sv
// Wishbone classic slave bundle between the Caravel bus
// and the configuration loader.
interface efpga_wb_cfg_loader_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
        input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i,
        output wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

endinterface

// File: rtl/efpga_cfg_fifo.sv
// Synchronous frame buffer with level/full/empty and a
// flush that has priority over push and pop.
module efpga_cfg_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    assign dout  = mem[rd_ptr];
    assign level = cnt;
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/efpga_wb_cfg_loader.sv
// Wishbone register window that queues bitstream frames and
// replays them into the fabric as LOAD/STROBE/HOLD sequences.
module efpga_wb_cfg_loader
    import efpga_cfg_pkg::*;
#(
    parameter int          FRAME_W    = 32,
    parameter int          NUM_ROWS   = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    efpga_wb_cfg_loader_if.slave    wbs,
    output logic [FRAME_W-1:0]      frame_data_o,
    output logic [NUM_ROWS-1:0]     frame_strobe_o,
    output logic                    cfg_busy_o
);

    localparam int LW = lvl_w(FIFO_DEPTH);
    localparam int EW = FRAME_W + ROW_W;

    logic             hit, acc, wr, data_wr, sel_ok;
    logic             stall, take, push, pop, soft_clr, go;
    logic [1:0]       off;
    logic [EW-1:0]    fifo_dout;
    logic [LW-1:0]    level;
    logic             full, empty;
    cfg_state_e       state_q, state_d;
    logic             en_q, err_q, ack_q;
    logic [ROW_W-1:0] row_q, cur_row_q;
    logic [15:0]      cnt_q;
    logic [31:0]      dat_q, rdata, status;
    logic             unused_ok;

    assign hit = wbs.wbs_stb_i & wbs.wbs_cyc_i
               & (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign acc      = hit & ~ack_q;
    assign off      = wbs.wbs_adr_i[3:2];
    assign wr       = acc & wbs.wbs_we_i;
    assign data_wr  = wr & (off == REG_DATA);
    assign sel_ok   = (wbs.wbs_sel_i == 4'hF);
    // A full FIFO still accepts a push in the cycle it pops.
    assign stall    = data_wr & sel_ok & full & ~pop;
    assign take     = acc & ~stall;
    assign push     = data_wr & sel_ok & ~stall;
    assign soft_clr = wr & (off == REG_CTRL)
                    & wbs.wbs_dat_i[CTRL_CLR];
    assign go       = en_q & ~empty;

    assign unused_ok = ^wbs.wbs_adr_i[1:0];

    efpga_cfg_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .flush (soft_clr),
        .push  (push),
        .din   ({row_q, wbs.wbs_dat_i[FRAME_W-1:0]}),
        .pop   (pop),
        .dout  (fifo_dout),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign cfg_busy_o    = ~empty | (state_q != S_IDLE);
    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;

    always_comb begin
        status = '0;
        status[7:0] = 8'(level);
        status[ST_BUSY] = cfg_busy_o;
        status[ST_ERR]  = err_q;
        status[ST_CNT_LSB +: 16] = cnt_q;
    end

    always_comb begin
        rdata = '0;
        unique case (off)
            REG_CTRL:   rdata[CTRL_EN] = en_q;
            REG_STATUS: rdata = status;
            REG_ROW:    rdata[ROW_W-1:0] = row_q;
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        frame_strobe_o = '0;
        if (state_q == S_STROBE)
            frame_strobe_o = NUM_ROWS'(1) << cur_row_q;
    end

    // HOLD chains straight into LOAD to sustain one frame per 3 cycles.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD:   state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            S_HOLD: begin
                if (go) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (soft_clr) begin
            state_d = S_IDLE;
            pop     = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= S_IDLE;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            en_q         <= 1'b0;
            err_q        <= 1'b0;
            row_q        <= '0;
            cur_row_q    <= '0;
            cnt_q        <= '0;
            frame_data_o <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= take;
            dat_q   <= (take && !wbs.wbs_we_i) ? rdata : '0;
            if (state_d == S_STROBE) cnt_q <= cnt_q + 16'd1;
            if (pop) begin
                frame_data_o <= fifo_dout[FRAME_W-1:0];
                cur_row_q    <= fifo_dout[EW-1:FRAME_W];
            end
            if (take && wbs.wbs_we_i) begin
                unique case (1'b1)
                    off == REG_CTRL:
                        en_q <= wbs.wbs_dat_i[CTRL_EN];
                    off == REG_STATUS:
                        if (wbs.wbs_dat_i[ST_ERR]) err_q <= 1'b0;
                    off == REG_ROW:
                        if (wbs.wbs_dat_i < 32'(NUM_ROWS))
                            row_q <= wbs.wbs_dat_i[ROW_W-1:0];
                        else
                            err_q <= 1'b1;
                    off == REG_DATA:
                        if (!sel_ok) err_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_efpga_wb_cfg_loader.sv
// Directed plus randomized bench for the frame loader, with a
// frame-queue reference model and a strobe scoreboard.
module tb_efpga_wb_cfg_loader;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          NR    = 16;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] frame_data;
    logic [15:0] strobe;
    logic        busy;

    efpga_wb_cfg_loader_if bus ();

    efpga_wb_cfg_loader #(
        .FRAME_W    (32),
        .NUM_ROWS   (NR),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_ni      (rst_n),
        .wbs            (bus),
        .frame_data_o   (frame_data),
        .frame_strobe_o (strobe),
        .cfg_busy_o     (busy)
    );

    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: queued frames in push order plus register state.
    logic [36:0] exp_q[$];
    int          st_cyc[$];
    logic [4:0]  m_row;
    bit          m_en;
    bit          m_err;
    int          m_pushed;
    int          m_dropped;
    logic        prev_hi;
    logic [36:0] mon_f;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_row     = '0;
        m_en      = 1'b0;
        m_err     = 1'b0;
        m_pushed  = 0;
        m_dropped = 0;
    endtask

    function automatic logic [31:0] exp_status(input int lvl,
                                               input bit bsy);
        int c;
        c = m_pushed - m_dropped - exp_q.size();
        return {c[15:0], 6'b0, m_err, bsy, lvl[7:0]};
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (strobe !== '0) begin
                st_cyc.push_back(cyc);
                check("strobe_width", {31'b0, prev_hi}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("strobe_unexpected", {16'b0, strobe}, 32'd0);
                end else begin
                    mon_f = exp_q.pop_front();
                    check("strobe_row", {16'b0, strobe},
                          32'd1 << mon_f[36:32]);
                    check("frame_data", frame_data, mon_f[31:0]);
                end
            end
            prev_hi = (strobe !== '0);
        end else begin
            prev_hi = 1'b0;
        end
    end

    task automatic xfer(input bit sync, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int max_wait,
                        output logic acked, output logic [31:0] rd,
                        output int lat);
        if (sync) @(negedge clk);
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        acked = 1'b0;
        rd    = '0;
        lat   = -1;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o === 1'b1) begin
                acked = 1'b1;
                rd    = bus.wbs_dat_o;
                lat   = i;
                break;
            end
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] off,
                      input logic [31:0] dat, input logic [3:0] sel);
        logic a;
        logic [31:0] r;
        int l;
        xfer(1'b1, 1'b1, BASE + off, dat, sel, 20, a, r, l);
        check({tag, "_ack"}, {31'b0, a}, 32'd1);
        check({tag, "_lat"}, l, 32'd0);
        if (a) begin
            case (off)
                32'h0: begin
                    m_en = dat[0];
                    if (dat[1]) begin
                        m_dropped += exp_q.size();
                        exp_q.delete();
                    end
                end
                32'h4: if (dat[9]) m_err = 1'b0;
                32'h8: begin
                    if (dat < NR) m_row = dat[4:0];
                    else m_err = 1'b1;
                end
                32'hC: begin
                    if (sel == 4'hF) begin
                        exp_q.push_back({m_row, dat});
                        m_pushed++;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] off,
                      output logic [31:0] val);
        logic a;
        int l;
        xfer(1'b1, 1'b0, BASE + off, 32'h0, 4'hF, 20, a, val, l);
        check({tag, "_ack"}, {31'b0, a}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check(tag, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        logic        a;
        int          l;
        int          t_ack;
        int          k;
        logic [3:0]  s;

        n_tests = 0;
        n_fail  = 0;
        prev_hi = 1'b0;
        model_reset();
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        check("rst_dat", bus.wbs_dat_o, 32'd0);
        check("rst_frame", frame_data, 32'd0);
        check("rst_strobe", {16'b0, strobe}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        rd("rst_status", 32'h4, v);
        check("rst_status_val", v, 32'd0);
        rd("rst_row", 32'h8, v);
        check("rst_row_val", v, 32'd0);
        rd("rst_ctrl", 32'h0, v);
        check("rst_ctrl_val", v, 32'd0);

        // Single frame to row 3
        st_cyc.delete();
        wr("t1_row", 32'h8, 32'd3, 4'hF);
        wr("t1_data", 32'hC, 32'hDEAD_BEEF, 4'hF);
        wr("t1_en", 32'h0, 32'd1, 4'hF);
        wait_idle("t1_drain");
        check("t1_nstrobe", st_cyc.size(), 32'd1);
        check("t1_data_held", frame_data, 32'hDEAD_BEEF);
        rd("t1_status", 32'h4, v);
        check("t1_count", {16'b0, v[31:16]}, 32'd1);

        // Nine pushes into an 8-deep buffer while disabled
        wr("t2_dis", 32'h0, 32'd0, 4'hF);
        st_cyc.delete();
        wr("t2_row", 32'h8, 32'd7, 4'hF);
        for (int i = 0; i < DEPTH; i++)
            wr("t2_push", 32'hC, $urandom, 4'hF);
        v = $urandom;
        xfer(1'b1, 1'b1, BASE + 32'hC, v, 4'hF, 6, a, v, l);
        check("t2_full_stall", {31'b0, a}, 32'd0);
        rd("t2_status", 32'h4, v);
        check("t2_status_val", v, exp_status(DEPTH, 1'b1));
        wr("t2_en", 32'h0, 32'd1, 4'hF);
        wr("t2_push9", 32'hC, 32'h0909_0909, 4'hF);
        wait_idle("t2_drain");
        check("t2_nstrobe", st_cyc.size(), 32'd9);
        for (int i = 1; i < st_cyc.size(); i++)
            check("t2_gap", st_cyc[i] - st_cyc[i-1], 32'd3);

        // Row tags captured at push time, with latency check
        st_cyc.delete();
        t_ack = 0;
        for (int i = 0; i < 3; i++) begin
            v = (i == 0) ? 32'd1 : (i == 1) ? 32'd2 : 32'd5;
            wr("t3_row", 32'h8, v, 4'hF);
            wr("t3_data", 32'hC, $urandom, 4'hF);
            if (i == 0) t_ack = cyc;
        end
        wait_idle("t3_drain");
        check("t3_nstrobe", st_cyc.size(), 32'd3);
        if (st_cyc.size() > 0)
            check("t3_latency", st_cyc[0] - t_ack, 32'd2);

        // Error sticky bit
        wr("t4_badrow", 32'h8, 32'd20, 4'hF);
        wr("t4_badsel", 32'hC, 32'h1234_5678, 4'h3);
        rd("t4_row", 32'h8, v);
        check("t4_row_val", v, {27'b0, m_row});
        rd("t4_status", 32'h4, v);
        check("t4_status_val", v, exp_status(0, 1'b0));
        wr("t4_clr", 32'h4, 32'h200, 4'hF);
        rd("t4_status2", 32'h4, v);
        check("t4_status2_val", v, exp_status(0, 1'b0));

        // Soft-clear while a strobe is on the fabric
        wr("t5_dis", 32'h0, 32'd0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            wr("t5_row", 32'h8, $urandom_range(0, NR-1), 4'hF);
            wr("t5_push", 32'hC, $urandom, 4'hF);
        end
        st_cyc.delete();
        wr("t5_en", 32'h0, 32'd1, 4'hF);
        a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (strobe !== '0) begin
                a = 1'b1;
                break;
            end
        end
        check("t5_strobe_seen", {31'b0, a}, 32'd1);
        xfer(1'b0, 1'b1, BASE, 32'd3, 4'hF, 3, a, v, l);
        check("t5_clr_ack", {31'b0, a}, 32'd1);
        check("t5_strobe_drop", {16'b0, strobe}, 32'd0);
        m_en = 1'b1;
        m_dropped += exp_q.size();
        exp_q.delete();
        rd("t5_status", 32'h4, v);
        check("t5_status_val", v, exp_status(0, 1'b0));
        repeat (15) @(negedge clk);
        check("t5_nstrobe", st_cyc.size(), 32'd1);

        // Outside the register window
        xfer(1'b1, 1'b1, BASE + 32'h10, 32'd0, 4'hF, 10, a, v, l);
        check("t6_nohit", {31'b0, a}, 32'd0);
        rd("t6_ctrl", 32'h0, v);
        check("t6_ctrl_val", v, {31'b0, m_en});

        // Asynchronous reset in the LOAD cycle
        wr("t7_row", 32'h8, 32'd9, 4'hF);
        xfer(1'b1, 1'b1, BASE + 32'hC, 32'hA5A5_1234, 4'hF, 5, a, v, l);
        check("t7_push_ack", {31'b0, a}, 32'd1);
        @(negedge clk);
        check("t7_load_data", frame_data, 32'hA5A5_1234);
        #1 rst_n = 1'b0;
        #1;
        check("t7_frame", frame_data, 32'd0);
        check("t7_strobe", {16'b0, strobe}, 32'd0);
        check("t7_busy", {31'b0, busy}, 32'd0);
        check("t7_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        check("t7_dat", bus.wbs_dat_o, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rd("t7_status", 32'h4, v);
        check("t7_status_val", v, 32'd0);

        // Randomized rounds: fill while disabled, then drain
        for (int r = 0; r < 6; r++) begin
            wr("rnd_dis", 32'h0, 32'd0, 4'hF);
            k = $urandom_range(4, 14);
            for (int i = 0; i < k; i++) begin
                case ($urandom_range(0, 3))
                    0: wr("rnd_row", 32'h8, $urandom_range(0, 23), 4'hF);
                    1: begin
                        if (exp_q.size() < DEPTH) begin
                            s = ($urandom_range(0, 3) == 0)
                                ? 4'($urandom_range(0, 14)) : 4'hF;
                            wr("rnd_data", 32'hC, $urandom, s);
                        end else begin
                            rd("rnd_stat", 32'h4, v);
                            check("rnd_stat_val", v,
                                  exp_status(exp_q.size(),
                                             exp_q.size() != 0));
                        end
                    end
                    2: wr("rnd_wstat", 32'h4, $urandom, 4'hF);
                    default: begin
                        rd("rnd_stat", 32'h4, v);
                        check("rnd_stat_val", v,
                              exp_status(exp_q.size(), exp_q.size() != 0));
                    end
                endcase
            end
            rd("rnd_row_rd", 32'h8, v);
            check("rnd_row_val", v, {27'b0, m_row});
            wr("rnd_en", 32'h0, 32'd1, 4'hF);
            wait_idle("rnd_drain");
            check("rnd_empty", exp_q.size(), 32'd0);
            rd("rnd_final", 32'h4, v);
            check("rnd_final_val", v, exp_status(0, 1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
